// File: rtl/sensor_frame_receiver_if.sv
// rtl/sensor_frame_receiver_if.sv - serial bit input and frame output bundle for sensor_frame_receiver
interface sensor_frame_receiver_if #(
  parameter int DATA_W = 35,
  parameter int CNT_W  = 8
);
  logic              sdata;
  logic              sbit_valid;
  logic [DATA_W-1:0] frame_data;
  logic              frame_wren;
  logic              busy;
  logic              frame_err;
  logic [CNT_W-1:0]  frame_cnt;

  modport master (
    output sdata, sbit_valid,
    input  frame_data, frame_wren, busy, frame_err, frame_cnt
  );

  modport slave (
    input  sdata, sbit_valid,
    output frame_data, frame_wren, busy, frame_err, frame_cnt
  );
endinterface

// File: rtl/sensor_frame_receiver.sv
// rtl/sensor_frame_receiver.sv - framed serial-to-parallel receiver feeding the house-state register
// Optional even-parity bit after the payload: define SENSOR_FRAME_PARITY_EN.
module sensor_frame_receiver #(
  parameter int DATA_W  = 35,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 8
) (
  input logic                    clk,
  input logic                    arst,
  sensor_frame_receiver_if.slave bus
);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [TMR_W-1:0] EXPIRE_AT = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

`ifdef SENSOR_FRAME_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shift;
  logic [IDX_W-1:0]  idx;
  logic [TMR_W-1:0]  timer;
  logic              par_ok;
  logic              commit, reject;
  logic              strobe, expire;

  assign strobe = bus.sbit_valid;
  // A strobe always beats an expiring timer.
  assign expire = !strobe && (timer == EXPIRE_AT);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    reject    = 1'b0;
    unique case (state)
      IDLE: begin
        if (strobe && !bus.sdata) state_nxt = DATA;
      end
      DATA: begin
        if (strobe) begin
          if (idx == LAST_IDX) state_nxt = AFTER_DATA;
        end else if (expire) begin
          reject    = 1'b1;
          state_nxt = IDLE;
        end
      end
      PARITY: begin
        if (strobe) begin
          state_nxt = STOP;
        end else if (expire) begin
          reject    = 1'b1;
          state_nxt = IDLE;
        end
      end
      STOP: begin
        if (strobe) begin
          commit    = bus.sdata && par_ok;
          reject    = !(bus.sdata && par_ok);
          state_nxt = IDLE;
        end else if (expire) begin
          reject    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      shift          <= '0;
      idx            <= '0;
      timer          <= '0;
      par_ok         <= 1'b1;
      bus.frame_data <= '0;
      bus.frame_wren <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.frame_cnt  <= '0;
    end else begin
      bus.frame_wren <= commit;
      bus.frame_err  <= reject;
      if (commit) begin
        bus.frame_data <= shift;
        bus.frame_cnt  <= bus.frame_cnt + CNT_W'(1);
      end

      if (state == IDLE) begin
        idx    <= '0;
        timer  <= '0;
        par_ok <= 1'b1;
      end else if (strobe) begin
        timer <= '0;
      end else begin
        timer <= timer + TMR_W'(1);
      end

      if (state == DATA && strobe) begin
        shift[idx] <= bus.sdata;
        idx        <= idx + IDX_W'(1);
      end

      // Even parity: payload bits and the parity bit must XOR to zero.
      if (state == PARITY && strobe) par_ok <= ~((^shift) ^ bus.sdata);
    end
  end
endmodule
